// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receiver, LSB-first data, optional parity, stop-bit check.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [WIDTH-1:0]   P_DATA,
    output logic               Data_Valid,
    output logic               Parity_Error,
    output logic               Stop_Error
);
    localparam int BW = $clog2(WIDTH + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t             state;
    logic [PRESC_W-1:0] presc, edge_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [WIDTH-1:0]   shreg;
    logic               par_en, par_typ, par_err, samp, bit_v, last, mid;
    assign last = edge_cnt == presc - PRESC_W'(1);
    assign mid  = edge_cnt == (presc >> 1);
`ifdef UART_RX_MAJORITY_EN
    logic samp_lo, samp_hi;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            samp_lo <= 1'b0;
            samp_hi <= 1'b0;
        end else begin
            if (edge_cnt == (presc >> 1) - PRESC_W'(1)) samp_lo <= RX_IN;
            if (edge_cnt == (presc >> 1) + PRESC_W'(1)) samp_hi <= RX_IN;
        end
    end
    assign bit_v = (samp_lo & samp) | (samp_lo & samp_hi) | (samp & samp_hi);
`else
    assign bit_v = samp;
`endif
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            presc        <= '0;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_en       <= 1'b0;
            par_typ      <= 1'b0;
            par_err      <= 1'b0;
            samp         <= 1'b0;
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            if (mid) samp <= RX_IN;
            if (state == IDLE) begin
                edge_cnt <= '0;
                // The detecting cycle is edge 0 of the start bit, so counting resumes at 1.
                if (!RX_IN) begin
                    state    <= START;
                    edge_cnt <= PRESC_W'(1);
                    presc    <= Prescale;
                    par_en   <= PAR_EN;
                    par_typ  <= PAR_TYP;
                    par_err  <= 1'b0;
                end
            end else begin
                edge_cnt <= last ? '0 : edge_cnt + PRESC_W'(1);
                if (last) begin
                    case (state)
                        START: begin
                            state   <= bit_v ? IDLE : DATA;
                            bit_cnt <= '0;
                        end
                        DATA: begin
                            shreg   <= {bit_v, shreg[WIDTH-1:1]};
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(WIDTH - 1)) state <= par_en ? PARITY : STOP;
                        end
                        PARITY: begin
                            par_err <= (^shreg ^ par_typ) != bit_v;
                            state   <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (!bit_v) Stop_Error <= 1'b1;
                            else if (par_err) Parity_Error <= 1'b1;
                            else begin
                                Data_Valid <= 1'b1;
                                P_DATA     <= shreg;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: randomized frames against a frame-level model, checked by a pulse scoreboard.
module tb_uart_rx_ctrl;
    logic       CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       Data_Valid, Parity_Error, Stop_Error;

    uart_rx_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] pdata;
        int         cyc;
    } exp_t;
    localparam logic [2:0] K_DV = 3'b100, K_PE = 3'b010, K_SE = 3'b001;

    exp_t       q[$];
    exp_t       e;
    int         checks = 0, failures = 0, cyc = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_p_data"}, 32'(P_DATA), 0);
        chk({tag, "_data_valid"}, 32'(Data_Valid), 0);
        chk({tag, "_parity_error"}, 32'(Parity_Error), 0);
        chk({tag, "_stop_error"}, 32'(Stop_Error), 0);
    endtask

    function automatic int rand_presc();
        return 8 << $urandom_range(0, 2);
    endfunction

    // Monitor: every pulse must match the oldest outstanding frame outcome.
    always @(negedge CLK) begin
        if (RST && (Data_Valid || Parity_Error || Stop_Error)) begin
            if (q.size() == 0) chk("unexpected_pulse", 32'({Data_Valid, Parity_Error, Stop_Error}), 0);
            else begin
                e = q.pop_front();
                chk("pulse_kind", 32'({Data_Valid, Parity_Error, Stop_Error}), 32'(e.kind));
                chk("p_data", 32'(P_DATA), 32'(e.pdata));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Called on a falling clock edge; drives one frame bit per P cycles.
    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int p,
                        input bit bad_par, input bit bad_stop, input int abort_bit, input int glitch_bit);
        logic [11:0] bits;
        int          n;
        exp_t        x;
        n       = 8 + int'(pe) + 2;
        bits    = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) bits[9] = ^d ^ pt ^ bad_par;
        bits[n-1] = ~bad_stop;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        Prescale = 6'(p);
        if (abort_bit < 0) begin
            x.kind = bad_stop ? K_SE : (pe && bad_par) ? K_PE : K_DV;
            if (x.kind == K_DV) last_good = d;
            x.pdata = last_good;
            x.cyc   = cyc + n * p;
            q.push_back(x);
        end
        for (int k = 0; k < n; k++) begin
            if (k == abort_bit) return;
            for (int j = 0; j < p; j++) begin
                RX_IN = (k == glitch_bit && j == p / 2) ? ~bits[k] : bits[k];
                if (k == 1 && j == 0) begin
                    PAR_EN   = 1'($urandom);
                    PAR_TYP  = 1'($urandom);
                    Prescale = 6'(rand_presc());
                end
                @(negedge CLK);
            end
        end
        RX_IN = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk_outputs_zero("reset");
        RST = 1'b1;
        @(negedge CLK);
        send(8'hA5, 1, 0, 8, 0, 0, -1, -1);
        repeat (4) @(negedge CLK);
        send(8'h3C, 0, 0, 16, 0, 0, -1, -1);
        send(8'hFF, 0, 0, 16, 0, 0, -1, -1);
        repeat (3) @(negedge CLK);
        send(8'h01, 1, 1, 8, 1, 0, -1, -1);
        repeat (3) @(negedge CLK);
        send(8'h55, 0, 0, 32, 0, 1, -1, -1);
        repeat (3) @(negedge CLK);
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (12) @(negedge CLK);
`ifdef UART_RX_MAJORITY_EN
        send(8'h00, 0, 0, 8, 0, 0, -1, 4);
        repeat (3) @(negedge CLK);
`endif
        send(8'h5A, 0, 0, 8, 0, 0, 5, -1);
        RST = 1'b0;
        @(negedge CLK);
        RX_IN = 1'b1;
        chk_outputs_zero("mid_reset");
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        last_good = 8'h00;
        @(negedge CLK);
        send(8'h81, 0, 0, 8, 0, 0, -1, -1);
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 1'($urandom), 1'($urandom), rand_presc(),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, -1, -1);
            repeat ($urandom_range(0, 4)) @(negedge CLK);
        end
        repeat (40) @(negedge CLK);
        chk("outstanding_frames", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
